ratio_scaler: RTL

- Parametrised successor to the fixed 12-bit a·b·cos(c)/(a+d) datapath.
- Computes y = a · b · k / (a + d) on one operand set at a time under valid/ready handshakes, with a programmable offset d.
  - k is a signed Q1.(W-1) coefficient, normally cosine from the existing ROM upstream.
  - Output y is sign-magnitude.
- Replaces the free-running pipeline and its FIFO with an FSM around a single iterative divider, so back-pressure and operand/quotient alignment hold by construction.

---
 rtl/ratio_scaler_pkg.sv | 18 +
 rtl/udiv_restoring.sv | 68 ++++++
 rtl/ratio_scaler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ratio_scaler_pkg.sv
// Shared definitions for the ratio scaler: FSM state encoding and the
// internal quotient width derived from the fraction-bit count.
package ratio_scaler_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    DIV  = 3'd2,
    MUL  = 3'd3,
    OUT  = 3'd4
  } state_t;

  // Quotient a/(a+d) is unsigned Q1.QF, so it needs one integer bit on top.
  function automatic int quot_width(input int qf);
    return qf + 1;
  endfunction

endpackage

// File: rtl/udiv_restoring.sv
// Iterative restoring divider: quotient = floor(dividend * 2^(QW-1) / divisor),
// one quotient bit per clock, MSB first. The first bit is resolved on the
// start edge itself, so the result is complete after QW edges and done pulses
// for one cycle right after the last bit. Requires dividend < 2*divisor so the
// quotient fits QW bits; a zero divisor yields 0 with the same timing.
// QW must be at least 2.
module udiv_restoring #(
  parameter int N  = 13,
  parameter int QW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  dividend,
  input  logic [N-1:0]  divisor,
  output logic [QW-1:0] quotient,
  output logic          done
);

  localparam int CW = $clog2(QW + 1);

  logic [N:0]    rem_reg;
  logic [QW-1:0] quo_reg;
  logic [CW-1:0] cnt_reg;
  logic          zero_reg;
  logic          done_reg;

  logic [N:0]    rem_cur;
  logic [N:0]    rem_next;
  logic [QW-1:0] quo_cur;
  logic          q_bit;

  // One restoring step: compare, conditionally subtract, pick the quotient bit.
  always_comb begin
    rem_cur  = start ? {1'b0, dividend} : rem_reg;
    quo_cur  = start ? '0 : quo_reg;
    q_bit    = (rem_cur >= {1'b0, divisor});
    rem_next = q_bit ? (rem_cur - {1'b0, divisor}) : rem_cur;
  end

  // Iteration state: load and take the first step on start, then step until the count runs out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      cnt_reg  <= '0;
      zero_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        rem_reg  <= rem_next << 1;
        quo_reg  <= (quo_cur << 1) | QW'(q_bit);
        zero_reg <= (divisor == '0);
        cnt_reg  <= CW'(QW - 1);
      end else if (cnt_reg != '0) begin
        rem_reg  <= rem_next << 1;
        quo_reg  <= (quo_cur << 1) | QW'(q_bit);
        cnt_reg  <= cnt_reg - 1'b1;
        done_reg <= (cnt_reg == CW'(1));
      end
    end
  end

  assign quotient = zero_reg ? '0 : quo_reg;
  assign done     = done_reg;

endmodule

// File: rtl/ratio_scaler.sv
// y = a * b * k / (a + d), one operand set at a time under valid/ready.
// The ratio a/(a+d) comes from an iterative divider; b*|k| is formed while
// the divider is being loaded, and the two are combined in a single multiply.
// The result is sign-magnitude {neg, mag} with negative zero suppressed.
module ratio_scaler
  import ratio_scaler_pkg::*;
#(
  parameter int W  = 12,
  parameter int QF = W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_d,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_k,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out_y,
  output logic         busy
);

  localparam int QW = quot_width(QF);

  state_t state_reg;
  state_t state_next;

  logic [W-1:0] d_reg;
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic [W-1:0] kmag_reg;
  logic         negk_reg;
  logic [W-1:0] dsnap_reg;
  logic [W-1:0] p_reg;
  logic [W:0]   out_y_reg;

  logic [W-1:0]      k_abs;
  logic [W:0]        sum;
  logic [2*W-1:0]    prod_bk;
  logic [QW+W-1:0]   prod_qp;
  logic [W-1:0]      mag;
  logic              neg;
  logic              div_start;
  logic              div_done;
  logic [QW-1:0]     quot;

  // Operand arithmetic: |k| (the most negative code maps to 2^(W-1)), a+D, b*|k| and q*p.
  always_comb begin
    k_abs   = in_k[W-1] ? (~in_k + 1'b1) : in_k;
    sum     = {1'b0, a_reg} + {1'b0, dsnap_reg};
    prod_bk = {{W{1'b0}}, b_reg} * {{W{1'b0}}, kmag_reg};
    prod_qp = {{W{1'b0}}, quot} * {{QW{1'b0}}, p_reg};
    mag     = W'(prod_qp >> QF);
    neg     = negk_reg & (mag != '0);
  end

  udiv_restoring #(
    .N  (W + 1),
    .QW (QW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend ({1'b0, a_reg}),
    .divisor  (sum),
    .quotient (quot),
    .done     (div_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, one cycle of prep, divide until done, multiply, hold result.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = PREP;
      PREP:    state_next = DIV;
      DIV:     if (div_done) state_next = MUL;
      MUL:     state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state only, so out_ready never reaches in_ready combinationally.
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == OUT);
    busy      = (state_reg != IDLE);
    div_start = (state_reg == PREP);
  end

  // Offset register, writable on any cycle; transactions use their own snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_reg <= '0;
    end else if (cfg_we) begin
      d_reg <= cfg_d;
    end
  end

  // Datapath registers: capture operands on accept, form p in PREP, register the result in MUL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      kmag_reg  <= '0;
      negk_reg  <= 1'b0;
      dsnap_reg <= '0;
      p_reg     <= '0;
      out_y_reg <= '0;
    end else begin
      if (state_reg == IDLE && in_valid) begin
        a_reg     <= in_a;
        b_reg     <= in_b;
        kmag_reg  <= k_abs;
        negk_reg  <= in_k[W-1];
        dsnap_reg <= d_reg;
      end
      if (state_reg == PREP) begin
        p_reg <= W'(prod_bk >> (W - 1));
      end
      if (state_reg == MUL) begin
        out_y_reg <= {neg, mag};
      end
    end
  end

  assign out_y = out_y_reg;

endmodule
